fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_skid_buffer.sv | 75 +++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath width, instruction size, fetch FSM
// state encoding and the buffered fetch-word layout.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  // One buffered fetch result: instruction word plus the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  // Sequential successor address; wraps naturally at the top of the space.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched {instr, pc} words between the RAM return
// path and decode. Flush empties it on the next edge and wins over push/pop.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [2*XLEN-1:0] push_data,
  input  logic              pop,
  output logic [2*XLEN-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [2*XLEN-1:0] mem_q [2];
  logic [2*XLEN-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 2'd1;
      end else if (do_pop && !do_push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: presents word addresses to the RAM, tracks the one
// outstanding read, buffers returned words in a 2-entry skid buffer and hands
// them to decode with valid/ready. Redirects flush everything and refetch.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps;
// otherwise the low two target bits are forced to zero).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  input  logic            ram_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            trap_fetch
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic            inflight_q, inflight_d;
  logic            trap_q, trap_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  fetch_word_t     push_word, head_word;
  logic [1:0]      occ_now, occ_after;
  logic            space_ok, issue;
  logic [XLEN-1:0] target;
  logic            misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign target     = redirect_pc & ~32'h0000_0003;
  assign misaligned = 1'b0;
`endif

  // Occupancy after this cycle's pop and pending capture; a new issue needs
  // one more slot, so it is allowed only while that total stays below two.
  // Counting the same-cycle pop is what sustains one word per cycle.
  always_comb begin
    occ_now   = {fifo_full, !fifo_full && !fifo_empty};
    occ_after = occ_now - {1'b0, fifo_pop} + {1'b0, inflight_q};
    space_ok  = (occ_after < 2'd2);
    // HOLD is recorded for visibility; issue re-evaluates stall and space
    // every cycle so leaving HOLD costs no bubble.
    issue     = (state_q != TRAP) && !ram_stall && space_ok && !redirect_valid;
  end

  // Next-state for pc, in-flight tracking and the fetch FSM.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    state_d    = state_q;
    trap_d     = trap_q;
    if (redirect_valid) begin
      pc_d       = target;
      inflight_d = 1'b0;
      state_d    = misaligned ? TRAP : RUN;
      trap_d     = misaligned;
    end else begin
      inflight_d = issue;
      if (issue) begin
        tag_d = pc_q;
        pc_d  = next_pc(pc_q);
      end
      if (state_q != TRAP) begin
        state_d = (ram_stall || !space_ok) ? HOLD : RUN;
      end
    end
  end

  // Fetch FSM and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      trap_q     <= trap_d;
    end
  end

  // Capture returning RAM data with its address; decode pops the head.
  always_comb begin
    fifo_push       = inflight_q && !redirect_valid;
    fifo_pop        = !fifo_empty && if_ready;
    push_word.instr = instruction;
    push_word.pc    = tag_q;
  end

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pc         = pc_q;
  assign if_valid   = !fifo_empty;
  assign if_instr   = head_word.instr;
  assign if_pc      = head_word.pc;
  assign trap_fetch = trap_q;

endmodule
